// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode tile renderer.
package text_pkg;
  localparam int FONT_AW     = 11;
  localparam int GLYPH_W     = 8;
  localparam int GLYPH_H     = 8;
  localparam int LEAD_CYCLES = 4;

  typedef logic [7:0]         char_code_t;
  typedef logic [GLYPH_W-1:0] glyph_row_t;
endpackage

// File: rtl/tile_shifter.sv
// Parallel-load, left-shifting glyph register; MSB is the pixel on screen.
// The invert flag is captured at load and applies to that cell's 8 pixels.
module tile_shifter
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       clear,
  input  glyph_row_t data,
  input  logic       invert,
  output logic       pixel
);

  glyph_row_t shreg;
  logic       invert_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg    <= '0;
      invert_q <= 1'b0;
    end else if (clear) begin
      shreg    <= '0;
      invert_q <= 1'b0;
    end else if (load) begin
      shreg    <= data;
      invert_q <= invert;
    end else begin
      shreg    <= {shreg[GLYPH_W-2:0], 1'b0};
    end
  end

  assign pixel = shreg[GLYPH_W-1] ^ invert_q;

endmodule

// File: rtl/text_tile_renderer.sv
// Text-mode pixel generator: char RAM -> font ROM -> 1-bit pixel stream.
// Optional block cursor is built when CURSOR_EN is defined.
module text_tile_renderer
  import text_pkg::*;
#(
  parameter int COLS   = 32,
  parameter int ROWS   = 30,
  parameter int RAM_AW = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hstart,
  input  logic [8:0]         vpos,
  output logic [RAM_AW-1:0]  ram_addr,
  input  char_code_t         ram_data,
  output logic [FONT_AW-1:0] font_addr,
  input  glyph_row_t         font_data,
  output logic               pixel_out,
  output logic               busy
`ifdef CURSOR_EN
  ,
  input  logic [5:0]         cursor_col,
  input  logic [4:0]         cursor_row,
  input  logic               cursor_on
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Phase within a cell: RAM read at 0, font address at 2, shifter load at 3.
  localparam logic [2:0] LOAD_PHASE = 3'(LEAD_CYCLES - 1);
  localparam logic [2:0] FONT_PHASE = 3'(LEAD_CYCLES - 2);

  logic [0:0] state;
  logic [2:0] phase;
  logic [6:0] col;
  logic [8:0] vpos_q;

  logic on_screen;
  logic in_cols;
  logic end_line;
  logic load;
  logic clear;
  logic cursor_hit;

  assign on_screen = 32'(vpos) < 32'(ROWS * GLYPH_H);
  assign in_cols   = col < 7'(COLS);
  // col reaches COLS only to drain the last cell; no fetch is issued for it.
  assign end_line  = (state == RUN) && (col == 7'(COLS)) && (phase == LOAD_PHASE);
  assign load      = (state == RUN) && !hstart && in_cols && (phase == LOAD_PHASE);
  assign clear     = hstart || end_line;

`ifdef CURSOR_EN
  assign cursor_hit = cursor_on && (col == {1'b0, cursor_col}) &&
                      (vpos_q[8:3] == {1'b0, cursor_row});
`else
  assign cursor_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase     <= '0;
      col       <= '0;
      vpos_q    <= '0;
      ram_addr  <= '0;
      font_addr <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= hstart ? ((state == RUN) && on_screen) : ((state == RUN) && !end_line);
      if (hstart) begin
        vpos_q <= vpos;
        phase  <= '0;
        col    <= '0;
        state  <= on_screen ? RUN : IDLE;
      end else if (state == RUN) begin
        if (end_line) begin
          state <= IDLE;
          phase <= '0;
          col   <= '0;
        end else begin
          phase <= phase + 3'd1;
          if (phase == 3'd7) col <= col + 7'd1;
        end
        if (in_cols && (phase == 3'd0))
          ram_addr <= RAM_AW'(32'(vpos_q[8:3]) * 32'(COLS) + 32'(col));
        if (in_cols && (phase == FONT_PHASE))
          font_addr <= {ram_data, vpos_q[2:0]};
      end
    end
  end

  tile_shifter u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .clear   (clear),
    .data    (font_data),
    .invert  (cursor_hit),
    .pixel   (pixel_out)
  );

endmodule
